// File: rtl/multi_clock_divider_if.sv
// Configuration write port of the multi-channel clock divider.
// The master presents one channel's period/high/enable; the divider accepts
// it when cfg_valid && cfg_ready.
interface multi_clock_divider_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) ();
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_high;
    logic             cfg_en;

    modport master (
        output cfg_valid, cfg_ch, cfg_period, cfg_high, cfg_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_period, cfg_high, cfg_en,
        output cfg_ready
    );
endinterface

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider.
// Each channel counts 0..P and drives clk_out high while the count is below H,
// with a tick strobe on count 0. New settings sit in a shadow register until a
// period boundary (wrap, sync, or the channel being idle) so the output never
// produces a runt pulse.
module multi_clock_divider #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    multi_clock_divider_if.slave   cfg,
    input  logic                   sync_i,
    output logic [NUM_CH-1:0]      clk_out_o,
    output logic [NUM_CH-1:0]      tick_o,
    output logic [NUM_CH-1:0]      active_o
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Live configuration and running state
    logic [CNT_W-1:0] c_q  [NUM_CH];
    logic [CNT_W-1:0] c_d  [NUM_CH];
    logic [CNT_W-1:0] p_q  [NUM_CH];
    logic [CNT_W-1:0] p_d  [NUM_CH];
    logic [CNT_W-1:0] h_q  [NUM_CH];
    logic [CNT_W-1:0] h_d  [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d;

    // Shadow configuration waiting for the next boundary
    logic [CNT_W-1:0] sp_q [NUM_CH];
    logic [CNT_W-1:0] sp_d [NUM_CH];
    logic [CNT_W-1:0] sh_q [NUM_CH];
    logic [CNT_W-1:0] sh_d [NUM_CH];
    logic [NUM_CH-1:0] sen_q, sen_d;
    logic [NUM_CH-1:0] pend_q, pend_d;

    // Registered outputs
    logic [NUM_CH-1:0] clk_q, clk_d;
    logic [NUM_CH-1:0] tick_q, tick_d;

    logic ready_w;

    // A channel takes a new write only once its previous one has been applied;
    // out-of-range channel numbers never stall.
    always_comb begin
        ready_w = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if ((cfg.cfg_ch == CH_W'(k)) && pend_q[k]) begin
                ready_w = 1'b0;
            end
        end
    end

    assign cfg.cfg_ready = ready_w;

    // Next-state: shadow load on accept, shadow-to-live at boundaries, counting.
    always_comb begin
        logic             acc;
        logic             apl;
        logic [CNT_W-1:0] nx;
        acc = 1'b0;
        apl = 1'b0;
        nx  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            c_d[k]    = c_q[k];
            p_d[k]    = p_q[k];
            h_d[k]    = h_q[k];
            en_d[k]   = en_q[k];
            sp_d[k]   = sp_q[k];
            sh_d[k]   = sh_q[k];
            sen_d[k]  = sen_q[k];
            pend_d[k] = pend_q[k];
            clk_d[k]  = 1'b0;
            tick_d[k] = 1'b0;

            acc = cfg.cfg_valid && ready_w && (cfg.cfg_ch == CH_W'(k));
            // An idle channel has no period to protect, so it applies at once.
            apl = pend_q[k] && (!en_q[k] || (c_q[k] == p_q[k]) || sync_i);

            if (acc) begin
                sp_d[k]   = cfg.cfg_period;
                sh_d[k]   = cfg.cfg_high;
                sen_d[k]  = cfg.cfg_en;
                pend_d[k] = 1'b1;
            end else if (apl) begin
                pend_d[k] = 1'b0;
            end

            if (apl) begin
                p_d[k]  = sp_q[k];
                h_d[k]  = sh_q[k];
                en_d[k] = sen_q[k];
            end

            // The wrap is purely a compare against P, so the counter never overflows.
            if (en_d[k]) begin
                if (apl || sync_i || (c_q[k] == p_q[k])) begin
                    nx = '0;
                end else begin
                    nx = c_q[k] + CNT_ONE;
                end
                c_d[k]    = nx;
                clk_d[k]  = (nx < h_d[k]);
                tick_d[k] = (nx == '0);
            end else begin
                c_d[k] = '0;
            end
        end
    end

    // State registers with synchronous reset of everything, including pending writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                c_q[k]  <= '0;
                p_q[k]  <= '0;
                h_q[k]  <= '0;
                sp_q[k] <= '0;
                sh_q[k] <= '0;
            end
            en_q   <= '0;
            sen_q  <= '0;
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                c_q[k]  <= c_d[k];
                p_q[k]  <= p_d[k];
                h_q[k]  <= h_d[k];
                sp_q[k] <= sp_d[k];
                sh_q[k] <= sh_d[k];
            end
            en_q   <= en_d;
            sen_q  <= sen_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;
    assign active_o  = en_q;

endmodule

// File: doc/multi_clock_divider.md
Name: multi_clock_divider

Overview:
- Parametrised, multi-channel successor of the single toggle-based clock scaler.
- Each of NUM_CH channels produces a divided clock with programmable period and high time (duty cycle), plus a one-cycle tick strobe at each period start.
- Each channel has its own enable.
- Configuration uses a valid/ready write port with shadow registers, so reconfiguration takes effect glitch-free at period boundaries.
- A global sync input phase-aligns all channels.
- The block sits between the system clock and the slow peripherals and timers that consume divided clocks or ticks.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 16, width of the period and high-time counters and fields.
- CH_W, $clog2(NUM_CH) (minimum 1), width of the channel select.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset: synchronous, active-high.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready.
- cfg_ch  in  CH_W  target channel; values >= NUM_CH are accepted and ignored.
- cfg_period  in  CNT_W  P: output period is P+1 clk cycles.
- cfg_high  in  CNT_W  H: clk_out high for H cycles per period.
- cfg_en  in  1  channel enable.
- sync  in  1  one-cycle pulse that restarts all enabled channels in phase.
- clk_out  out  NUM_CH  registered divided clocks.
- tick  out  NUM_CH  one-cycle pulse, asserted in the cycle whose counter value is 0.
- active  out  NUM_CH  channel currently running.

Behaviour:
- Reset: when rst=1 at a clock edge:
  - all counters, live P/H/en, shadow P/H/en, and pending flags are set to 0;
  - clk_out=0, tick=0, active=0;
  - cfg_ready=1 from the first cycle after reset.
- Per-channel state:
  - counter c (CNT_W bits);
  - live P, H, en;
  - shadow P, H, en;
  - pending flag.
- Write accept:
  - cfg_ready = !pending[cfg_ch] (combinational); it is 1 for an out-of-range cfg_ch.
  - On accept, the shadow is loaded and pending is set.
  - A second write to the same channel stalls until the apply cycle has cleared pending.
  - The earliest re-accept is the cycle after the apply.
- Apply (shadow to live, pending cleared) happens at the first of the following:
  - (a) the channel is inactive: apply in the cycle after accept;
  - (b) an active channel wraps (c==P);
  - (c) sync=1.
- Run rule per active cycle:
  - c' = (c==P) ? 0 : c+1, using the live P, or 0 if an apply or sync occurs this cycle;
  - clk_out' = (c' < H) computed with the P/H that is live after the edge;
  - tick' = (c'==0).
- Duty extremes:
  - H=0 gives clk_out constant 0 with ticks still produced.
  - H>=P+1 gives clk_out constant 1.
  - P=0 gives tick high every cycle and clk_out=(H!=0).
- Enable from idle:
  - after an accept in cycle t, the apply is in t+1;
  - in t+2, active=1, c=0, tick=1, clk_out=(H!=0).
- Disable (en=0 applied):
  - takes effect only at a wrap or sync, never mid-period;
  - on that edge c=0, clk_out=0, tick=0, active=0.
- sync:
  - all active channels go to c=0, tick=1, clk_out=(H!=0) on the same edge;
  - all pending shadows apply on that edge;
  - sync has priority over a wrap in the same cycle;
  - an accept in the same cycle as sync is applied at the next boundary, not this one.
- Idle channels hold clk_out=0, tick=0.
- Compatibility: the old divider (scale S, toggle) equals P=2S+1, H=S+1.
- Width rules:
  - counters wrap only through the c==P compare, so no arithmetic overflow is possible;
  - P = 2^CNT_W-1 is legal.
- Reset mid-operation: outputs return to reset values on the next edge; pending writes are discarded.

Test Plan:
- Reset, then write ch0 P=3 H=2 en=1 -> from the apply, ch0 clk_out = 1,1,0,0 repeating; tick every 4 cycles in the first '1' cycle; active=1.
- Legacy equivalence: ch1 P=5 H=3 -> clk_out 3 high, 3 low, matching the old scaler with S=2; ch0 is unaffected.
- Mid-period reconfigure of active ch0 (P=3 to P=7 H=4 at c=1):
  - cfg_ready[ch0] is low until the wrap;
  - the old pattern completes;
  - the new 8-cycle pattern starts at c=0 with no runt pulse;
  - a second write during pending stalls.
- Duty extremes on ch2: H=0 -> clk_out stuck 0 with ticks; H=10 with P=3 -> stuck 1; P=0 H=1 -> tick every cycle.
- Sync: ch0 P=3 and ch1 P=5 running out of phase, pulse sync -> both tick and restart at c=0 on the same edge; a sync coinciding with a wrap yields a single tick.
- Disable/reset:
  - en=0 written at c=1 -> clk_out goes low only after the period ends, then active=0;
  - rst asserted mid-pattern with a pending write -> all outputs 0 next edge, cfg_ready=1, and the pending config is never applied.
